// File: rtl/data_point_fifo.sv
// First-word fall-through queue of data points between the input converter and the mapper.
// Status flags are decoded from the registered count only, so ready/write never reach them combinationally.
module data_point_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_res,
    input  logic                  i_fifo_write,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_full,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_BITS:0]    o_count,
    output logic                  o_overflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_r;
    logic [ADDR_BITS-1:0]  rd_ptr_r;
    logic [ADDR_BITS:0]    count_r;
    logic                  overflow_r;
    logic                  full_s;
    logic                  valid_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign full_s      = (count_r == DEPTH_C);
    assign valid_s     = (count_r != {(ADDR_BITS + 1){1'b0}});
    assign o_fifo_full = full_s;
    assign o_valid     = valid_s;
    assign o_count     = count_r;
    assign o_overflow  = overflow_r;
    assign o_data      = mem_r[rd_ptr_r];

    // Accept decisions; a synchronous clear suppresses both transfers.
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (i_res) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            wr_en_s = i_fifo_write & ~full_s;
            rd_en_s = valid_s & i_ready;
        end
    end

    // Storage array, intentionally left without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_fifo_data;
        end
    end

    // Pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {ADDR_BITS{1'b0}};
            rd_ptr_r   <= {ADDR_BITS{1'b0}};
            count_r    <= {(ADDR_BITS + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (i_res) begin
            wr_ptr_r   <= {ADDR_BITS{1'b0}};
            rd_ptr_r   <= {ADDR_BITS{1'b0}};
            count_r    <= {(ADDR_BITS + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (i_fifo_write && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_point_fifo.sv
// Directed bench for data_point_fifo: reset, fill/overflow, simultaneous full/empty cases,
// pointer wrap streaming and clear behaviour, all against hand-computed values.
module tb_data_point_fifo;

    localparam int DW = 128;
    localparam int AB = 4;

    logic          clk;
    logic          reset;
    logic          i_res;
    logic          i_fifo_write;
    logic [DW-1:0] i_fifo_data;
    logic          o_fifo_full;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [AB:0]   o_count;
    logic          o_overflow;

    int err_cnt;
    int chk_cnt;

    data_point_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_res        (i_res),
        .i_fifo_write (i_fifo_write),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_full  (o_fifo_full),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp_v) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit after it.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        i_fifo_write = w;
        i_fifo_data  = d;
        i_ready      = r;
        @(posedge clk);
        #1;
        i_fifo_write = 1'b0;
        i_ready      = 1'b0;
    endtask

    initial begin
        err_cnt      = 0;
        chk_cnt      = 0;
        reset        = 1'b1;
        i_res        = 1'b0;
        i_fifo_write = 1'b0;
        i_fifo_data  = '0;
        i_ready      = 1'b0;
        #12;
        check_eq("rst_count", DW'(o_count), DW'(0));
        check_eq("rst_valid", DW'(o_valid), DW'(0));
        check_eq("rst_full",  DW'(o_fifo_full), DW'(0));
        check_eq("rst_ovf",   DW'(o_overflow), DW'(0));
        @(negedge clk);
        reset = 1'b0;

        // Three writes, no reader; first write visible right after its edge
        cyc(1'b1, DW'(1), 1'b0);
        check_eq("lat_valid", DW'(o_valid), DW'(1));
        check_eq("lat_data",  o_data, DW'(1));
        cyc(1'b1, DW'(2), 1'b0);
        cyc(1'b1, DW'(3), 1'b0);
        check_eq("w3_count", DW'(o_count), DW'(3));
        check_eq("w3_data",  o_data, DW'(1));
        check_eq("w3_valid", DW'(o_valid), DW'(1));
        for (int k = 1; k <= 3; k++) begin
            check_eq("w3_drain", o_data, DW'(k));
            cyc(1'b0, '0, 1'b1);
        end
        check_eq("w3_empty", DW'(o_count), DW'(0));

        // Fill to full, then one write too many
        for (int k = 0; k < 16; k++) cyc(1'b1, DW'(k), 1'b0);
        check_eq("fill_full",  DW'(o_fifo_full), DW'(1));
        check_eq("fill_count", DW'(o_count), DW'(16));
        check_eq("fill_ovf0",  DW'(o_overflow), DW'(0));
        cyc(1'b1, DW'(99), 1'b0);
        check_eq("ovf_flag",  DW'(o_overflow), DW'(1));
        check_eq("ovf_count", DW'(o_count), DW'(16));
        check_eq("ovf_head",  o_data, DW'(0));

        // Full with write and read together: read wins, write dropped
        cyc(1'b1, DW'(77), 1'b1);
        check_eq("fr_count", DW'(o_count), DW'(15));
        check_eq("fr_ovf",   DW'(o_overflow), DW'(1));
        check_eq("fr_full",  DW'(o_fifo_full), DW'(0));
        for (int k = 1; k < 16; k++) begin
            check_eq("fill_order", o_data, DW'(k));
            cyc(1'b0, '0, 1'b1);
        end
        check_eq("drain_count", DW'(o_count), DW'(0));
        check_eq("drain_valid", DW'(o_valid), DW'(0));

        // Empty with write and ready together: no read that cycle
        cyc(1'b1, DW'('hA), 1'b1);
        check_eq("ew_count", DW'(o_count), DW'(1));
        check_eq("ew_valid", DW'(o_valid), DW'(1));
        check_eq("ew_data",  o_data, DW'('hA));
        cyc(1'b0, '0, 1'b1);
        check_eq("ew_read", DW'(o_count), DW'(0));

        // Stream 40 points with a continuously ready consumer
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, DW'(32'h100 + k), 1'b1);
            check_eq("st_data",  o_data, DW'(32'h100 + k));
            check_eq("st_count", DW'(o_count), DW'(1));
        end
        cyc(1'b0, '0, 1'b1);
        check_eq("st_end", DW'(o_count), DW'(0));

        // Async reset with 5 entries and overflow still set
        for (int k = 0; k < 5; k++) cyc(1'b1, DW'(32'h200 + k), 1'b0);
        check_eq("pre_rst_count", DW'(o_count), DW'(5));
        check_eq("pre_rst_ovf",   DW'(o_overflow), DW'(1));
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_count", DW'(o_count), DW'(0));
        check_eq("arst_valid", DW'(o_valid), DW'(0));
        check_eq("arst_ovf",   DW'(o_overflow), DW'(0));
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, DW'(32'h55), 1'b0);
        check_eq("arst_wr_data",  o_data, DW'(32'h55));
        check_eq("arst_wr_count", DW'(o_count), DW'(1));
        cyc(1'b0, '0, 1'b1);

        // Synchronous clear with 5 entries and overflow set; simultaneous traffic ignored
        for (int k = 0; k < 16; k++) cyc(1'b1, DW'(k), 1'b0);
        cyc(1'b1, DW'(99), 1'b0);
        for (int k = 0; k < 11; k++) cyc(1'b0, '0, 1'b1);
        check_eq("pre_res_count", DW'(o_count), DW'(5));
        check_eq("pre_res_ovf",   DW'(o_overflow), DW'(1));
        i_res = 1'b1;
        cyc(1'b1, DW'(32'h66), 1'b1);
        i_res = 1'b0;
        check_eq("res_count", DW'(o_count), DW'(0));
        check_eq("res_valid", DW'(o_valid), DW'(0));
        check_eq("res_ovf",   DW'(o_overflow), DW'(0));
        cyc(1'b1, DW'(32'h77), 1'b0);
        check_eq("res_wr_data",  o_data, DW'(32'h77));
        check_eq("res_wr_count", DW'(o_count), DW'(1));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/data_point_fifo.md
DATA_POINT_FIFO -- requirements
Module: data_point_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of one data point (DIMENSION*PRECISION).
REQ-002 Parameter ADDR_BITS, default 4: log2 of storage depth; DEPTH = 2**ADDR_BITS = 16 entries.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port i_res  input  1  synchronous clear of contents, count and overflow flag.
REQ-006 Port i_fifo_write  input  1  write strobe from input converter.
REQ-007 Port i_fifo_data  input  DATA_WIDTH  point to store.
REQ-008 Port o_fifo_full  output  1  high when count == DEPTH; drives converter i_fifo_full.
REQ-009 Port o_data  output  DATA_WIDTH  head-of-queue point (first-word fall-through).
REQ-010 Port o_valid  output  1  high when count != 0.
REQ-011 Port i_ready  input  1  consumer (mapper) accepts o_data when o_valid && i_ready.
REQ-012 Port o_count  output  ADDR_BITS+1  number of stored points, 0..DEPTH.
REQ-013 Port o_overflow  output  1  sticky: a write was attempted while full.

Function
REQ-014 Write accepted iff i_fifo_write && !o_fifo_full; data stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-015 Read accepted iff o_valid && i_ready; rd_ptr increments modulo DEPTH.
REQ-016 o_data shall equal mem[rd_ptr] combinationally; undefined-but-stable content when o_valid low.
REQ-017 Latency: point written on edge N shall appear on o_data with o_valid high after edge N (cycle N+1) if queue was empty.
REQ-018 o_count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-019 Full and read same cycle: write rejected (full evaluated on current count), read accepted, count becomes DEPTH-1.
REQ-020 Empty and write same cycle: read not accepted (o_valid low), write accepted, count becomes 1.
REQ-021 Write while full shall set o_overflow, leave memory, pointers and count unchanged.
REQ-022 Pointers shall wrap from DEPTH-1 to 0 without affecting count or order; order strictly FIFO.
REQ-023 o_fifo_full and o_valid shall be decoded from registered count, no combinational path from i_fifo_write or i_ready.
REQ-024 i_res high on an edge: pointers, count, o_overflow cleared; any simultaneous write or read ignored.
REQ-025 Memory contents need not be reset.

Reset
REQ-026 reset asserted (any time, incl. mid-transfer): wr_ptr=0, rd_ptr=0, o_count=0, o_overflow=0, o_valid=0, o_fifo_full=0 immediately, without clock.
REQ-027 First write accepted on the first rising edge after reset deasserts.

Verification
REQ-028 Reset, write 0x1,0x2,0x3 on consecutive cycles, i_ready=0 -> o_count=3, o_data=0x1, o_valid=1.
REQ-029 Fill 16 points with i_ready=0 -> o_fifo_full=1, o_count=16; 17th write -> o_overflow=1, count stays 16, drained data 0..15 in order.
REQ-030 Full, i_fifo_write=1 and i_ready=1 same cycle -> one read, write dropped, o_count=15, o_overflow=1.
REQ-031 Empty, write 0xA with i_ready=1 -> no read that cycle; next cycle o_valid=1, o_data=0xA, read accepted, o_count returns 0.
REQ-032 Stream 40 points at 1/cycle with i_ready=1 continuously -> pointers wrap twice, output sequence identical to input, o_count stays <=1.
REQ-033 Assert reset (and separately i_res) with 5 entries stored -> o_count=0, o_valid=0, o_overflow=0; next write reads back correctly.
